// File: rtl/sipo_dispatcher_if.sv
// Slot-side and stream-side signals between sipo_buffer, the dispatcher and the downstream sink.
// The dispatcher connects through the slave modport; the environment drives through master.
interface sipo_dispatcher_if #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 8,
  parameter int CNT_W  = 16
);
  localparam int SLOT_W = $clog2(LENGTH);

  logic [WIDTH-1:0]  slot_data [LENGTH];
  logic [LENGTH-1:0] slot_valid;
  logic [LENGTH-1:0] clr_ps;
  logic              flush;
  logic [WIDTH-1:0]  out_data;
  logic [SLOT_W-1:0] out_slot;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  disp_cnt;

  modport master (
    output slot_data, slot_valid, flush, out_ready,
    input  clr_ps, out_data, out_slot, out_valid, disp_cnt
  );

  modport slave (
    input  slot_data, slot_valid, flush, out_ready,
    output clr_ps, out_data, out_slot, out_valid, disp_cnt
  );
endinterface

// File: rtl/sipo_dispatcher.sv
// sipo_dispatcher: drains occupied sipo_buffer slots, one per cycle in round-robin order,
// into a one-entry registered valid/ready stage and frees each slot on the edge it is captured.
module sipo_dispatcher #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  sipo_dispatcher_if.slave bus
);
  localparam int SLOT_W = $clog2(LENGTH);

  logic [WIDTH-1:0]  r_out_data;
  logic [SLOT_W-1:0] r_out_slot;
  logic              r_out_valid;
  logic [SLOT_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0]  r_disp_cnt;

  logic [SLOT_W-1:0] w_grant_hi;
  logic [SLOT_W-1:0] w_grant_lo;
  logic              w_found_hi;
  logic              w_found_lo;
  logic [SLOT_W-1:0] w_grant;
  logic              w_any;
  logic              w_load;
  logic              w_cap;

  // Round-robin search: lowest valid slot at or above rr_ptr wins, otherwise lowest valid slot below it.
  always_comb begin
    w_grant_hi = '0;
    w_grant_lo = '0;
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    for (int i = LENGTH - 1; i >= 0; i--) begin
      if (bus.slot_valid[i]) begin
        if (i >= int'(r_rr_ptr)) begin
          w_grant_hi = SLOT_W'(i);
          w_found_hi = 1'b1;
        end else begin
          w_grant_lo = SLOT_W'(i);
          w_found_lo = 1'b1;
        end
      end
    end
    w_grant = w_found_hi ? w_grant_hi : w_grant_lo;
    w_any   = w_found_hi | w_found_lo;
  end

  // Capture qualification; reset is folded in so clr_ps drops the moment rst rises.
  always_comb begin
    w_load = !r_out_valid || bus.out_ready;
    w_cap  = w_load && w_any && !bus.flush && !rst;
  end

  assign bus.clr_ps    = w_cap ? (LENGTH'(1) << w_grant) : '0;
  assign bus.out_data  = r_out_data;
  assign bus.out_slot  = r_out_slot;
  assign bus.out_valid = r_out_valid;
  assign bus.disp_cnt  = r_disp_cnt;

  // Output stage, round-robin pointer and dispatch counter; flush only empties the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_slot  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_disp_cnt  <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (w_any) begin
        r_out_data  <= bus.slot_data[w_grant];
        r_out_slot  <= w_grant;
        r_out_valid <= 1'b1;
        r_rr_ptr    <= (w_grant == SLOT_W'(LENGTH - 1)) ? '0 : w_grant + 1'b1;
        r_disp_cnt  <= r_disp_cnt + 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_dispatcher.sv
// Bench for sipo_dispatcher: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-free behavioural model of the dispatcher.
module tb_sipo_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sipo_dispatcher_if #(.WIDTH(32), .LENGTH(8), .CNT_W(16)) ifc ();
  sipo_dispatcher_if #(.WIDTH(8),  .LENGTH(5), .CNT_W(4))  ifc5 ();

  sipo_dispatcher #(.WIDTH(32), .LENGTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(ifc.slave)
  );

  sipo_dispatcher #(.WIDTH(8), .LENGTH(5), .CNT_W(4)) u_dut5 (
    .clk(clk), .rst(rst), .bus(ifc5.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_slot;
  int          m_rr;
  int          m_cnt;
  bit          m_load;
  bit          m_cap;
  int          m_g;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [7:0] v, input int rr);
    for (int k = 0; k < 8; k++)
      if (v[(rr + k) % 8]) return (rr + k) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_slot  = 0;
    m_rr    = 0;
    m_cnt   = 0;
    m_cap   = 1'b0;
    m_g     = -1;
  endtask

  // Compare all outputs against the model just before the edge.
  task automatic sample();
    @(negedge clk);
    m_load = !m_valid || ifc.out_ready;
    m_g    = model_grant(ifc.slot_valid, m_rr);
    m_cap  = m_load && (m_g >= 0) && !ifc.flush;
    chk("out_valid", 64'(ifc.out_valid), 64'(m_valid));
    chk("out_data",  64'(ifc.out_data),  64'(m_data));
    chk("out_slot",  64'(ifc.out_slot),  64'(m_slot));
    chk("disp_cnt",  64'(ifc.disp_cnt),  64'(m_cnt));
    chk("clr_ps",    64'(ifc.clr_ps),    m_cap ? (64'd1 << m_g) : 64'd0);
  endtask

  // Clock the model and emulate the buffer freeing the captured slot.
  task automatic advance();
    @(posedge clk);
    if (ifc.flush) begin
      m_valid = 1'b0;
    end else if (m_load) begin
      if (m_g >= 0) begin
        m_valid = 1'b1;
        m_data  = ifc.slot_data[m_g];
        m_slot  = m_g;
        m_rr    = (m_g + 1) % 8;
        m_cnt   = (m_cnt + 1) % 65536;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    if (m_cap) ifc.slot_valid[m_g] = 1'b0;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ifc.slot_data[i] = 32'h0;
    for (int i = 0; i < 5; i++) ifc5.slot_data[i] = 8'h0;
    ifc.slot_valid  = '0;
    ifc.flush       = 1'b0;
    ifc.out_ready   = 1'b1;
    ifc5.slot_valid = '0;
    ifc5.flush      = 1'b0;
    ifc5.out_ready  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // idle after reset
    repeat (3) step();
    chk("idle out_valid", 64'(ifc.out_valid), 64'd0);
    chk("idle disp_cnt",  64'(ifc.disp_cnt),  64'd0);

    // two slots, round-robin order 2 then 5
    for (int i = 0; i < 8; i++) ifc.slot_data[i] = 32'hA000_0000 + 32'(i);
    ifc.slot_valid = 8'b0010_0100;
    sample();
    chk("rr first clr", 64'(ifc.clr_ps), 64'h04);
    advance();
    sample();
    chk("rr second clr", 64'(ifc.clr_ps), 64'h20);
    chk("rr first slot", 64'(ifc.out_slot), 64'd2);
    chk("rr first data", 64'(ifc.out_data), 64'hA000_0002);
    advance();
    sample();
    chk("rr second slot", 64'(ifc.out_slot), 64'd5);
    chk("rr cnt2", 64'(ifc.disp_cnt), 64'd2);
    advance();
    // rr_ptr now 6: slot 6 must beat slot 0
    ifc.slot_valid = 8'b0100_0001;
    sample();
    chk("rr ptr6 clr", 64'(ifc.clr_ps), 64'h40);
    advance();
    sample();
    chk("rr after6 clr", 64'(ifc.clr_ps), 64'h01);
    advance();

    // wrap from rr_ptr 7
    ifc.slot_valid = 8'b0100_0000;
    step();
    ifc.slot_valid = 8'b1000_0001;
    sample();
    chk("wrap clr7", 64'(ifc.clr_ps), 64'h80);
    advance();
    sample();
    chk("wrap clr0", 64'(ifc.clr_ps), 64'h01);
    advance();
    step();

    // stall holding slot 3
    ifc.slot_valid = 8'b0000_1000;
    step();
    ifc.out_ready = 1'b0;
    ifc.slot_valid[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("stall slot", 64'(ifc.out_slot), 64'd3);
      chk("stall data", 64'(ifc.out_data), 64'hA000_0003);
      chk("stall clr",  64'(ifc.clr_ps),   64'h00);
      advance();
    end
    ifc.out_ready = 1'b1;
    sample();
    chk("release clr", 64'(ifc.clr_ps), 64'h02);
    advance();
    repeat (2) step();

    // flush while holding a word
    ifc.out_ready  = 1'b0;
    ifc.slot_valid = 8'b0001_0000;
    step();
    chk("pre-flush cnt", 64'(ifc.disp_cnt), 64'd10);
    ifc.slot_valid = 8'b0000_0011;
    ifc.out_ready  = 1'b1;
    ifc.flush      = 1'b1;
    sample();
    chk("flush clr", 64'(ifc.clr_ps), 64'h00);
    advance();
    ifc.flush     = 1'b0;
    ifc.out_ready = 1'b0;
    sample();
    chk("flush valid", 64'(ifc.out_valid), 64'd0);
    chk("flush cnt",   64'(ifc.disp_cnt),  64'd10);
    chk("post-flush clr", 64'(ifc.clr_ps), 64'h01);
    advance();
    ifc.slot_valid = '0;
    ifc.out_ready  = 1'b1;
    repeat (2) step();

    // reset, then full burst in slot order
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    ifc.slot_valid = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      sample();
      chk("burst clr", 64'(ifc.clr_ps), 64'd1 << (i % 8));
      advance();
      ifc.slot_valid = 8'hFF;
    end
    chk("burst slot", 64'(ifc.out_slot), 64'd3);
    // asynchronous reset mid-burst
    rst = 1'b1;
    #1;
    chk("arst valid", 64'(ifc.out_valid), 64'd0);
    chk("arst data",  64'(ifc.out_data),  64'd0);
    chk("arst slot",  64'(ifc.out_slot),  64'd0);
    chk("arst cnt",   64'(ifc.disp_cnt),  64'd0);
    chk("arst clr",   64'(ifc.clr_ps),    64'd0);
    model_reset();
    ifc.slot_valid = '0;
    #1 rst = 1'b0;

    // LENGTH=5 wrap 4 -> 0
    for (int i = 0; i < 5; i++) ifc5.slot_data[i] = 8'(8'h50 + i);
    ifc5.slot_valid = 5'b10000;
    @(negedge clk);
    chk("l5 clr4", 64'(ifc5.clr_ps), 64'h10);
    @(posedge clk);
    #1 ifc5.slot_valid = 5'b00011;
    @(negedge clk);
    chk("l5 clr0", 64'(ifc5.clr_ps), 64'h01);
    chk("l5 slot4", 64'(ifc5.out_slot), 64'd4);
    chk("l5 data4", 64'(ifc5.out_data), 64'h54);
    @(posedge clk);
    #1 ifc5.slot_valid = 5'b00010;
    @(negedge clk);
    chk("l5 clr1", 64'(ifc5.clr_ps), 64'h02);
    chk("l5 slot0", 64'(ifc5.out_slot), 64'd0);
    @(posedge clk);
    #1 ifc5.slot_valid = '0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.flush     = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 8; i++) begin
        if (!ifc.slot_valid[i] && $urandom_range(0, 2) == 0) begin
          ifc.slot_data[i]  = $urandom;
          ifc.slot_valid[i] = 1'b1;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
